// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control logic:
// register index width, EX operand-select encoding and the shadow-stage
// records used by the forwarding/hazard unit.
package riscv_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 32;

  // Select code for the EX-stage 3:1 operand muxes. 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Shadow of the instruction currently in EX. Sources are kept because the
  // forwarding decision is made for this instruction.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 uses_rs1;
    logic                 uses_rs2;
  } ex_info_t;

  // Shadow of the instruction currently in MEM.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } mem_info_t;

  // Shadow of the instruction currently in WB.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
  } wb_info_t;

  // True when a producer stage will write register 'rs'. x0 never matches,
  // since writes to it are discarded by the register file.
  function automatic logic produces_reg(
    input logic                 valid,
    input logic                 regwrite,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs
  );
    return valid && regwrite && (rd != '0) && (rd == rs);
  endfunction

  // Event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand-select priority compare for one EX source operand against the
// MEM and WB producers. MEM holds the younger result, so it wins over WB.
module fwd_sel
  import riscv_pkg::*;
(
  input  logic                 uses,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 mem_valid,
  input  logic                 mem_regwrite,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic                 wb_valid,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output fwd_sel_e             sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = uses && produces_reg(mem_valid, mem_regwrite, mem_rd, rs);
  assign wb_hit  = uses && produces_reg(wb_valid, wb_regwrite, wb_rd, rs);

  // Pick the youngest in-flight producer, falling back to the register file.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline. Keeps a shadow
// of the destination info in EX/MEM/WB, derives the EX operand selects from
// it, and produces load-use stall, bubble and branch-flush controls plus
// saturating stall/flush event counters.
module fwd_hazard_unit
  import riscv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_regwrite_i,
  input  logic                 id_memread_i,
  input  logic                 ex_branch_taken_i,
  output logic [1:0]           forward_a_o,
  output logic [1:0]           forward_b_o,
  output logic                 stall_o,
  output logic                 bubble_o,
  output logic                 flush_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  localparam int NUM_OPERANDS = 2;

  // Shadow pipeline state and its next values
  ex_info_t   ex_reg;
  ex_info_t   ex_next;
  mem_info_t  mem_reg;
  mem_info_t  mem_next;
  wb_info_t   wb_reg;
  wb_info_t   wb_next;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_next;

  logic load_use;
  logic stall;
  logic bubble;
  logic flush;

  // Per-operand views of the EX instruction, index 0 = A/rs1, 1 = B/rs2
  logic [NUM_OPERANDS-1:0]                ex_uses;
  logic [NUM_OPERANDS-1:0][REG_IDX_W-1:0] ex_rs;
  fwd_sel_e                               fwd_sel_arr [NUM_OPERANDS];

  // The MEM load flag travels with the shadow record but no decision here
  // depends on it: load-use is resolved while the load is still in EX.
  logic unused_mem_memread;
  assign unused_mem_memread = mem_reg.memread;

  assign ex_uses = {ex_reg.uses_rs2, ex_reg.uses_rs1};
  assign ex_rs   = {ex_reg.rs2, ex_reg.rs1};

  // One priority selector per EX source operand
  generate
    for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_fwd
      fwd_sel u_fwd_sel (
        .uses         (ex_uses[gi]),
        .rs           (ex_rs[gi]),
        .mem_valid    (mem_reg.valid),
        .mem_regwrite (mem_reg.regwrite),
        .mem_rd       (mem_reg.rd),
        .wb_valid     (wb_reg.valid),
        .wb_regwrite  (wb_reg.regwrite),
        .wb_rd        (wb_reg.rd),
        .sel          (fwd_sel_arr[gi])
      );
    end
  endgenerate

  assign forward_a_o = fwd_sel_arr[0];
  assign forward_b_o = fwd_sel_arr[1];

  // Load-use detection against the ID instruction; a taken branch overrides
  // the stall because the ID instruction is being discarded anyway.
  always_comb begin
    load_use = ex_reg.valid && ex_reg.memread && (ex_reg.rd != '0) && id_valid_i &&
               ((id_uses_rs1_i && (id_rs1_i == ex_reg.rd)) ||
                (id_uses_rs2_i && (id_rs2_i == ex_reg.rd)));
    flush    = ex_branch_taken_i;
    stall    = load_use && !ex_branch_taken_i;
    bubble   = load_use || ex_branch_taken_i;
  end

  assign stall_o  = stall;
  assign bubble_o = bubble;
  assign flush_o  = flush;

  // Shadow advance: a bubble turns the incoming EX slot into an all-zero NOP
  always_comb begin
    ex_next = '0;
    if (!bubble) begin
      ex_next.valid    = id_valid_i;
      ex_next.rd       = id_rd_i;
      ex_next.regwrite = id_regwrite_i;
      ex_next.memread  = id_memread_i;
      ex_next.rs1      = id_rs1_i;
      ex_next.rs2      = id_rs2_i;
      ex_next.uses_rs1 = id_uses_rs1_i;
      ex_next.uses_rs2 = id_uses_rs2_i;
    end

    mem_next.valid    = ex_reg.valid;
    mem_next.rd       = ex_reg.rd;
    mem_next.regwrite = ex_reg.regwrite;
    mem_next.memread  = ex_reg.memread;

    wb_next.valid     = mem_reg.valid;
    wb_next.rd        = mem_reg.rd;
    wb_next.regwrite  = mem_reg.regwrite;
  end

  // Event counters count the cycle that is ending at this edge
  always_comb begin
    stall_cnt_next = stall ? sat_inc(stall_cnt_reg) : stall_cnt_reg;
    flush_cnt_next = flush ? sat_inc(flush_cnt_reg) : flush_cnt_reg;
  end

  // Shadow stages and counters; reset empties the pipeline immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_reg        <= '0;
      mem_reg       <= '0;
      wb_reg        <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      ex_reg        <= ex_next;
      mem_reg       <= mem_next;
      wb_reg        <= wb_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// random instruction streams, all compared against a history-based model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        br_taken;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic        bubble;
  logic        flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int passed = 0;

  fwd_hazard_unit dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .id_valid_i        (id_valid),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_uses_rs1_i     (id_uses_rs1),
    .id_uses_rs2_i     (id_uses_rs2),
    .id_rd_i           (id_rd),
    .id_regwrite_i     (id_regwrite),
    .id_memread_i      (id_memread),
    .ex_branch_taken_i (br_taken),
    .forward_a_o       (forward_a),
    .forward_b_o       (forward_b),
    .stall_o           (stall),
    .bubble_o          (bubble),
    .flush_o           (flush),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: the last three instructions that entered EX, newest first.
  // Entry 0 is in EX, 1 in MEM, 2 in WB. A bubble enters as an all-zero NOP.
  typedef struct {
    bit valid;
    int rd;
    bit regwrite;
    bit memread;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } rec_t;

  rec_t        hist[$];
  longint      m_stall_cnt;
  longint      m_flush_cnt;

  function automatic rec_t nop_rec();
    rec_t r;
    r = '{valid: 0, rd: 0, regwrite: 0, memread: 0, rs1: 0, rs2: 0, u1: 0, u2: 0};
    return r;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(nop_rec());
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  function automatic bit writes(rec_t r, int rs);
    return r.valid && r.regwrite && (r.rd != 0) && (r.rd == rs);
  endfunction

  // Youngest producer wins; nothing is forwarded for an unused operand
  function automatic logic [1:0] exp_fwd(bit uses, int rs);
    if (!uses) return 2'b00;
    if (writes(hist[1], rs)) return 2'b10;
    if (writes(hist[2], rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_hazard();
    rec_t e;
    e = hist[0];
    return e.valid && e.memread && (e.rd != 0) && id_valid &&
           ((id_uses_rs1 && (int'(id_rs1) == e.rd)) || (id_uses_rs2 && (int'(id_rs2) == e.rd)));
  endfunction

  function automatic logic [31:0] sat32(longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic void model_advance();
    bit   hz;
    rec_t r;
    hz = exp_hazard();
    if (hz && !br_taken) m_stall_cnt++;
    if (br_taken) m_flush_cnt++;
    r = nop_rec();
    if (!(hz || br_taken)) begin
      r = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
            rs1: id_rs1, rs2: id_rs2, u1: id_uses_rs1, u2: id_uses_rs2};
    end
    hist.push_front(r);
    void'(hist.pop_back());
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    bit hz;
    hz = exp_hazard();
    chk({tag, ".fwd_a"}, 32'(forward_a), 32'(exp_fwd(hist[0].u1, hist[0].rs1)));
    chk({tag, ".fwd_b"}, 32'(forward_b), 32'(exp_fwd(hist[0].u2, hist[0].rs2)));
    chk({tag, ".stall"}, 32'(stall), 32'(hz && !br_taken));
    chk({tag, ".bubble"}, 32'(bubble), 32'(hz || br_taken));
    chk({tag, ".flush"}, 32'(flush), 32'(br_taken));
    chk({tag, ".stall_cnt"}, stall_cnt, sat32(m_stall_cnt));
    chk({tag, ".flush_cnt"}, flush_cnt, sat32(m_flush_cnt));
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit br);
    id_valid    = v;
    id_rs1      = 5'(rs1);
    id_uses_rs1 = u1;
    id_rs2      = 5'(rs2);
    id_uses_rs2 = u2;
    id_rd       = 5'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    br_taken    = br;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs driven: check, clock, advance
  task automatic step(input string tag);
    #1;
    check_all(tag);
    $display("step %-14s fa=%b fb=%b st=%b bu=%b fl=%b sc=%0d fc=%0d",
             tag, forward_a, forward_b, stall, bubble, flush, stall_cnt, flush_cnt);
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges, then release on a falling edge
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    set_idle();
    #1;
    model_reset();
    chk({tag, ".rst_fa"}, 32'(forward_a), 32'd0);
    chk({tag, ".rst_fb"}, 32'(forward_b), 32'd0);
    chk({tag, ".rst_st"}, 32'(stall), 32'd0);
    chk({tag, ".rst_bu"}, 32'(bubble), 32'd0);
    chk({tag, ".rst_fl"}, 32'(flush), 32'd0);
    chk({tag, ".rst_sc"}, stall_cnt, 32'd0);
    chk({tag, ".rst_fc"}, flush_cnt, 32'd0);
    $display("reset %s", tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    do_reset("init");

    // add x5 in MEM, EX reads x5 on rs1
    set_id(1, 1, 0, 2, 0, 5, 1, 0, 0); step("add_x5");
    set_id(1, 5, 1, 3, 1, 6, 1, 0, 0); step("use_x5_id");
    set_idle(); #1;
    chk("t1.fwd_a_mem", 32'(forward_a), 32'd2);
    chk("t1.fwd_b_rf", 32'(forward_b), 32'd0);
    step("use_x5_ex");

    // x5 written by MEM and WB -> MEM priority; then MEM write removed -> WB
    do_reset("t2");
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step("wb_prod");
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step("mem_prod");
    set_id(1, 1, 1, 5, 1, 8, 1, 0, 0); step("use_rs2_id");
    set_idle(); #1;
    chk("t2.fwd_b_mem_prio", 32'(forward_b), 32'd2);
    step("use_rs2_ex");
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step("wb_prod2");
    set_id(1, 0, 0, 0, 0, 5, 0, 0, 0); step("mem_nowrite");
    set_id(1, 1, 1, 5, 1, 8, 1, 0, 0); step("use_rs2_id2");
    set_idle(); #1;
    chk("t2.fwd_b_wb", 32'(forward_b), 32'd1);
    step("use_rs2_ex2");

    // lw x7 then use of x7: one stall cycle, then WB forward
    do_reset("t3");
    set_id(1, 2, 1, 0, 0, 7, 1, 1, 0); step("lw_x7");
    set_id(1, 7, 1, 4, 1, 9, 1, 0, 0); #1;
    chk("t3.stall_on", 32'(stall), 32'd1);
    chk("t3.bubble_on", 32'(bubble), 32'd1);
    step("use_x7_stall");
    #1;
    chk("t3.stall_off", 32'(stall), 32'd0);
    chk("t3.stall_cnt", stall_cnt, 32'd1);
    step("use_x7_held");
    set_idle(); #1;
    chk("t3.fwd_a_wb", 32'(forward_a), 32'd1);
    step("use_x7_ex");

    // x0 producers never forward; lw x0 never stalls
    do_reset("t4");
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); step("wr_x0_a");
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); step("wr_x0_b");
    set_id(1, 0, 1, 0, 1, 3, 1, 0, 0); step("use_x0_id");
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0); #1;
    chk("t4.fwd_a_x0", 32'(forward_a), 32'd0);
    chk("t4.fwd_b_x0", 32'(forward_b), 32'd0);
    step("lw_x0");
    set_id(1, 0, 1, 0, 1, 3, 1, 0, 0); #1;
    chk("t4.no_stall_x0", 32'(stall), 32'd0);
    step("use_x0_after_lw");

    // load-use hazard together with a taken branch: flush wins
    do_reset("t5");
    set_id(1, 2, 1, 0, 0, 7, 1, 1, 0); step("lw_x7_b");
    set_id(1, 7, 1, 0, 0, 9, 1, 0, 1); #1;
    chk("t5.stall", 32'(stall), 32'd0);
    chk("t5.flush", 32'(flush), 32'd1);
    chk("t5.bubble", 32'(bubble), 32'd1);
    step("hz_and_br");
    set_idle(); #1;
    chk("t5.flush_cnt", flush_cnt, 32'd1);
    chk("t5.stall_cnt", stall_cnt, 32'd0);
    step("after_br");

    // random streams over a small register range to provoke many matches
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", n));
    end

    // reset dropped with valid shadows, then first instruction reads x5
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step("pre_rst_a");
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); step("pre_rst_b");
    do_reset("t6");
    set_id(1, 5, 1, 5, 1, 6, 1, 0, 0); step("post_rst_id");
    set_idle(); #1;
    chk("t6.fwd_a_empty", 32'(forward_a), 32'd0);
    chk("t6.fwd_b_empty", 32'(forward_b), 32'd0);
    step("post_rst_ex");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and hazard controller for the 5-stage RISC-V pipeline. It keeps its own shadow copy of the destination-register information flowing through EX, MEM and WB. From that copy it drives the 2-bit operand-select codes consumed by the EX-stage 3:1 operand muxes. It also generates load-use stall, bubble and branch-flush controls for the IF/ID and ID/EX pipeline registers, and counts stall and flush events for performance monitoring.

## Interface
- No parameters; register-index width (5) and select encoding come from the shared package.
- clk_i  input  1  pipeline clock.
- rst_ni  input  1  reset; one clock, reset is asynchronous and active-low.
- id_valid_i  input  1  the ID stage holds a real instruction.
- id_rs1_i, id_rs2_i  input  5 each  source register indices of the ID instruction.
- id_uses_rs1_i, id_uses_rs2_i  input  1 each  the ID instruction actually reads rs1/rs2.
- id_rd_i  input  5  destination index of the ID instruction.
- id_regwrite_i  input  1  the ID instruction writes the register file.
- id_memread_i  input  1  the ID instruction is a load.
- ex_branch_taken_i  input  1  the branch/jump in EX is resolved taken this cycle.
- forward_a_o, forward_b_o  output  2 each  operand select for the instruction in EX: 00 regfile, 01 WB result, 10 MEM result.
- stall_o  output  1  hold PC and IF/ID this cycle.
- bubble_o  output  1  ID/EX loads a NOP at the next edge.
- flush_o  output  1  kill the IF/ID contents at the next edge.
- stall_cnt_o, flush_cnt_o  output  32 each  saturating event counters.

## Operation
- Shadow stages: EX {valid, rd, regwrite, memread, rs1, rs2, uses_rs1, uses_rs2}, MEM {valid, rd, regwrite, memread}, WB {valid, rd, regwrite}. They advance every edge: WB<=MEM, MEM<=EX, EX<=ID inputs.
- When bubble_o=1, EX loads valid=0; MEM and WB still advance.
- Forwarding, per operand, for the EX instruction (e.g. A uses rs1):
  - 10 (MEM) if EX.uses && MEM.valid && MEM.regwrite && MEM.rd!=0 && MEM.rd==EX.rs.
  - Else 01 (WB) if the same conditions hold for WB.
  - Else 00.
  - MEM has priority over WB. Code 11 is never driven.
- Load-use hazard: EX.valid && EX.memread && EX.rd!=0 && id_valid_i && ((id_uses_rs1_i && id_rs1_i==EX.rd) || (id_uses_rs2_i && id_rs2_i==EX.rd)).
  - On a hazard: stall_o=1 and bubble_o=1.
  - The stall lasts exactly one cycle, because the inserted bubble clears the condition.
- Branch taken: flush_o=1 and bubble_o=1; the ID instruction is discarded.
- Simultaneous hazard and branch taken: flush wins. stall_o=0, flush_o=1, bubble_o=1.
- Counters:
  - stall_cnt_o increments on each cycle with stall_o=1.
  - flush_cnt_o increments on each cycle with flush_o=1.
  - Both saturate at 32'hFFFF_FFFF.
- Register x0 never matches: no forwarding and no hazard.
- The register file is write-before-read, so no WB-to-ID forwarding is produced here.

## Timing
- Reset values:
  - All shadow valid bits 0, all shadow fields 0.
  - forward_a_o=forward_b_o=00, stall_o=bubble_o=flush_o=0, counters 0.
- Reset mid-operation clears all state immediately, with no dependence on the clock; the pipeline resumes as empty.
- forward_*_o: combinational from shadow flops only, stable early in the cycle.
- stall_o, bubble_o, flush_o: combinational, zero latency from ID inputs and ex_branch_taken_i; consumed at the next rising edge.
- Counters update at the edge that ends the counted cycle and are visible the following cycle.

## Structure
- Shared package riscv_pkg holds:
  - enum fwd_sel_e: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_IDX_W=5.
  - structs ex_info_t, mem_info_t and wb_info_t for the shadow stages.
- Sub-module fwd_sel: combinational priority compare of one operand against MEM/WB. Instantiated twice, once for A and once for B.
- Top level holds the shadow flops, hazard/flush logic and counters.

## Test plan
- add x5 in MEM, EX reads x5 on rs1 -> forward_a_o=10, forward_b_o=00.
- x5 written by both MEM and WB, EX reads x5 on rs2 -> forward_b_o=10 (MEM priority); with the MEM write removed -> 01.
- lw x7 in EX, ID reads x7 -> stall_o=bubble_o=1 for exactly 1 cycle; next cycle stall_o=0 and forward=01 once the load reaches WB; stall_cnt_o=1.
- Writes to x0 in MEM/WB, EX reads x0 -> forward 00; lw x0 followed by a use of x0 -> no stall.
- Load-use hazard and ex_branch_taken_i=1 in the same cycle -> stall_o=0, flush_o=1, bubble_o=1; flush_cnt_o=1, stall_cnt_o=0.
- rst_ni dropped mid-stream with valid shadows -> all outputs 00/0 and counters 0 asynchronously; the first instruction after release gets forward 00.
